// File: rtl/a_verif_cmd_pkg.sv
// Shared definitions for the emulation control-verification command master.
// Holds the opcode encodings, where the header fields sit in a host word,
// the fill word returned for a missing readback, and the FSM state encoding.
package a_verif_cmd_pkg;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  localparam int HDR_OP_MSB  = 15;
  localparam int HDR_OP_LSB  = 14;
  localparam int HDR_IDX_MSB = 7;
  localparam int HDR_IDX_LSB = 0;

  localparam logic [15:0] RSP_DEAD = 16'hDEAD;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_GET_LO,
    ST_GET_HI,
    ST_ARM,
    ST_WR_LO,
    ST_WR_HI,
    ST_RD_WAIT0,
    ST_RSP0,
    ST_RD_WAIT1,
    ST_RSP1
  } state_e;

endpackage

// File: rtl/a_verif_rsp_reg.sv
// One-deep response holding register toward the host response path.
// Ports:
//   clk_ref, rst_n  - reference clock, asynchronous active-low reset
//   load, load_data - write a new word (caller only loads when not occupied)
//   rsp_busy_i      - host path full; word is held while high
//   rsp_valid_o     - word present
//   rsp_data_o      - held word
//   occupied        - register full (drives the slaves' busy input)
module a_verif_rsp_reg (
  input  logic        clk_ref,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] load_data,
  input  logic        rsp_busy_i,
  output logic        rsp_valid_o,
  output logic [15:0] rsp_data_o,
  output logic        occupied
);

  always_ff @(posedge clk_ref or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_o <= 1'b0;
      rsp_data_o  <= 16'h0000;
    end else if (load) begin
      rsp_valid_o <= 1'b1;
      rsp_data_o  <= load_data;
    end else if (rsp_valid_o && !rsp_busy_i) begin
      rsp_valid_o <= 1'b0;
    end
  end

  assign occupied = rsp_valid_o;

endmodule

// File: rtl/a_verif_cmd_master.sv
// Command initiator for the control-verification bus.
// Decodes host header words (NOP / WRITE / READ), drives the registered
// select / r_w / dv / data strobes toward the slave bank, and returns the two
// readback words of a READ through a one-deep response register.
// Ports:
//   clk_ref, rst_n                 - reference clock, async active-low reset
//   cmd_valid_i/cmd_data_i/cmd_ready_o - host command word handshake
//   rsp_valid_o/rsp_data_o/rsp_busy_i  - host response word, held while busy
//   select_module_o, r_w_o, dv_o, data_o - slave bus strobes (registered)
//   busy_o                         - response register occupied
//   rd_dv_i, rd_data_i             - per-slave readback pulse and data
//   err_o                          - sticky error, cleared only by reset
import a_verif_cmd_pkg::*;

module a_verif_cmd_master #(
  parameter int N_MOD   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk_ref,
  input  logic                  rst_n,
  input  logic                  cmd_valid_i,
  input  logic [15:0]           cmd_data_i,
  output logic                  cmd_ready_o,
  output logic                  rsp_valid_o,
  output logic [15:0]           rsp_data_o,
  input  logic                  rsp_busy_i,
  output logic [N_MOD-1:0]      select_module_o,
  output logic                  r_w_o,
  output logic                  dv_o,
  output logic [15:0]           data_o,
  output logic                  busy_o,
  input  logic [N_MOD-1:0]      rd_dv_i,
  input  logic [16*N_MOD-1:0]   rd_data_i,
  output logic                  err_o
);

  localparam int IDX_W = (N_MOD > 1) ? $clog2(N_MOD) : 1;
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               dead_q;
  logic [15:0]        wr_lo_q, wr_hi_q;
  logic               ready_q, err_q;

  logic [1:0]         hdr_op;
  logic [7:0]         hdr_idx;
  logic               hdr_bad_idx, cmd_fire, sel_dv, timed_out;
  logic [15:0]        sel_data;
  logic               err_set, cnt_clr, dead_set, dead_clr, lo_load, hi_load;
  logic               rsp_load, rsp_occ;
  logic [15:0]        rsp_load_data;

  logic [N_MOD-1:0]   sel_d;
  logic               rw_d, dv_d, ready_d;
  logic [15:0]        data_d;
  logic               unused_hdr;

  assign hdr_op      = cmd_data_i[HDR_OP_MSB:HDR_OP_LSB];
  assign hdr_idx     = cmd_data_i[HDR_IDX_MSB:HDR_IDX_LSB];
  assign unused_hdr  = ^cmd_data_i[13:8];
  assign hdr_bad_idx = (int'(hdr_idx) >= N_MOD);
  assign cmd_fire    = cmd_valid_i && ready_q;
  assign sel_dv      = rd_dv_i[idx_q];
  assign sel_data    = rd_data_i[{idx_q, 4'b0000} +: 16];
  // Once the first readback word timed out the second one is not waited for.
  assign timed_out   = dead_q || (cnt_q == CNT_W'(TIMEOUT));

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    err_set       = 1'b0;
    cnt_clr       = 1'b0;
    dead_set      = 1'b0;
    dead_clr      = 1'b0;
    lo_load       = 1'b0;
    hi_load       = 1'b0;
    rsp_load      = 1'b0;
    rsp_load_data = 16'h0000;
    case (state_q)
      ST_IDLE: begin
        if (cmd_fire) begin
          case (hdr_op)
            OP_WRITE, OP_READ: begin
              if (hdr_bad_idx) begin
                err_set = 1'b1;
              end else begin
                idx_d = hdr_idx[IDX_W-1:0];
                if (hdr_op == OP_WRITE) begin
                  state_d = ST_GET_LO;
                end else begin
                  state_d  = ST_RD_WAIT0;
                  cnt_clr  = 1'b1;
                  dead_clr = 1'b1;
                end
              end
            end
            OP_RSVD: err_set = 1'b1;
            default: ;
          endcase
        end
      end
      ST_GET_LO: if (cmd_fire) begin lo_load = 1'b1; state_d = ST_GET_HI; end
      ST_GET_HI: if (cmd_fire) begin hi_load = 1'b1; state_d = ST_ARM; end
      ST_ARM:    state_d = ST_WR_LO;
      ST_WR_LO:  state_d = ST_WR_HI;
      ST_WR_HI:  state_d = ST_IDLE;
      ST_RD_WAIT0, ST_RD_WAIT1: begin
        if (!rsp_occ) begin
          if (!dead_q && sel_dv) begin
            rsp_load      = 1'b1;
            rsp_load_data = sel_data;
            state_d       = (state_q == ST_RD_WAIT0) ? ST_RSP0 : ST_RSP1;
          end else if (timed_out) begin
            err_set       = 1'b1;
            dead_set      = 1'b1;
            rsp_load      = 1'b1;
            rsp_load_data = RSP_DEAD;
            state_d       = (state_q == ST_RD_WAIT0) ? ST_RSP0 : ST_RSP1;
          end
        end
      end
      // Leave as the held word retires so the slave sees busy_o fall together
      // with the master being ready for the next word.
      ST_RSP0: if (!rsp_occ || !rsp_busy_i) begin state_d = ST_RD_WAIT1; cnt_clr = 1'b1; end
      ST_RSP1: if (!rsp_occ || !rsp_busy_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Bus strobes are decoded from the next state and registered.
  always_comb begin
    sel_d = '0;
    if (state_d inside {ST_ARM, ST_WR_LO, ST_WR_HI, ST_RD_WAIT0, ST_RSP0, ST_RD_WAIT1})
      sel_d[idx_d] = 1'b1;
    rw_d    = state_d inside {ST_ARM, ST_WR_LO, ST_WR_HI};
    dv_d    = state_d inside {ST_WR_LO, ST_WR_HI};
    ready_d = state_d inside {ST_IDLE, ST_GET_LO, ST_GET_HI};
    data_d  = 16'h0000;
    if (state_d == ST_WR_LO) data_d = wr_lo_q;
    if (state_d == ST_WR_HI) data_d = wr_hi_q;
  end

  always_ff @(posedge clk_ref or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      idx_q           <= '0;
      cnt_q           <= '0;
      dead_q          <= 1'b0;
      err_q           <= 1'b0;
      ready_q         <= 1'b0;
      select_module_o <= '0;
      r_w_o           <= 1'b0;
      dv_o            <= 1'b0;
      data_o          <= 16'h0000;
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      ready_q         <= ready_d;
      select_module_o <= sel_d;
      r_w_o           <= rw_d;
      dv_o            <= dv_d;
      data_o          <= data_d;
      if (err_set) err_q <= 1'b1;
      if (dead_clr) dead_q <= 1'b0;
      else if (dead_set) dead_q <= 1'b1;
      if (cnt_clr) cnt_q <= '0;
      else if ((state_q == ST_RD_WAIT0 || state_q == ST_RD_WAIT1) && cnt_q != CNT_W'(TIMEOUT))
        cnt_q <= cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_ref) begin
    if (lo_load) wr_lo_q <= cmd_data_i;
    if (hi_load) wr_hi_q <= cmd_data_i;
  end

  a_verif_rsp_reg u_rsp_reg (
    .clk_ref     (clk_ref),
    .rst_n       (rst_n),
    .load        (rsp_load),
    .load_data   (rsp_load_data),
    .rsp_busy_i  (rsp_busy_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_data_o  (rsp_data_o),
    .occupied    (rsp_occ)
  );

  assign cmd_ready_o = ready_q;
  assign busy_o      = rsp_occ;
  assign err_o       = err_q;

endmodule

// File: tb/tb_a_verif_cmd_master.sv
// Directed bench for a_verif_cmd_master (N_MOD=8, TIMEOUT=255).
module tb_a_verif_cmd_master;

  logic         clk_ref = 1'b0;
  logic         rst_n;
  logic         cmd_valid_i;
  logic [15:0]  cmd_data_i;
  logic         cmd_ready_o;
  logic         rsp_valid_o;
  logic [15:0]  rsp_data_o;
  logic         rsp_busy_i;
  logic [7:0]   select_module_o;
  logic         r_w_o;
  logic         dv_o;
  logic [15:0]  data_o;
  logic         busy_o;
  logic [7:0]   rd_dv_i;
  logic [127:0] rd_data_i;
  logic         err_o;

  int checks   = 0;
  int failures = 0;

  a_verif_cmd_master #(.N_MOD(8), .TIMEOUT(255)) dut (
    .clk_ref         (clk_ref),
    .rst_n           (rst_n),
    .cmd_valid_i     (cmd_valid_i),
    .cmd_data_i      (cmd_data_i),
    .cmd_ready_o     (cmd_ready_o),
    .rsp_valid_o     (rsp_valid_o),
    .rsp_data_o      (rsp_data_o),
    .rsp_busy_i      (rsp_busy_i),
    .select_module_o (select_module_o),
    .r_w_o           (r_w_o),
    .dv_o            (dv_o),
    .data_o          (data_o),
    .busy_o          (busy_o),
    .rd_dv_i         (rd_dv_i),
    .rd_data_i       (rd_data_i),
    .err_o           (err_o)
  );

  always #5 clk_ref = ~clk_ref;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_ref);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Presents one word and returns on the negedge after it was accepted.
  task automatic send_word(input logic [15:0] w);
    int n = 0;
    cmd_valid_i = 1'b1;
    cmd_data_i  = w;
    while (!cmd_ready_o && n < 100) begin
      tick();
      n++;
    end
    if (!cmd_ready_o) check_eq("send_timeout", 32'(cmd_ready_o), 32'd1);
    tick();
    cmd_valid_i = 1'b0;
  endtask

  task automatic do_write(input string tag, input logic [7:0] idx, input logic [7:0] sel,
                          input logic [15:0] lo, input logic [15:0] hi);
    send_word({2'b01, 6'd0, idx});
    send_word(lo);
    send_word(hi);
    check_eq({tag, "_arm_sel"}, 32'(select_module_o), 32'(sel));
    check_eq({tag, "_arm_rw"},  32'(r_w_o), 32'd1);
    check_eq({tag, "_arm_dv"},  32'(dv_o), 32'd0);
    tick();
    check_eq({tag, "_lo_dv"},   32'(dv_o), 32'd1);
    check_eq({tag, "_lo_data"}, 32'(data_o), 32'(lo));
    check_eq({tag, "_lo_sel"},  32'(select_module_o), 32'(sel));
    tick();
    check_eq({tag, "_hi_dv"},   32'(dv_o), 32'd1);
    check_eq({tag, "_hi_data"}, 32'(data_o), 32'(hi));
    check_eq({tag, "_hi_sel"},  32'(select_module_o), 32'(sel));
    tick();
    check_eq({tag, "_end_sel"}, 32'(select_module_o), 32'd0);
    check_eq({tag, "_end_dv"},  32'(dv_o), 32'd0);
    check_eq({tag, "_end_rsp"}, 32'(rsp_valid_o), 32'd0);
  endtask

  // Slave model: answers once selected and the master is not busy, then
  // checks the word shows up on the response port the next cycle.
  task automatic slave_word(input string tag, input int idx, input logic [15:0] d);
    int n = 0;
    while (!(select_module_o[idx] && !busy_o) && n < 100) begin
      tick();
      n++;
    end
    check_eq({tag, "_slave_sel"}, 32'(select_module_o[idx] && !busy_o), 32'd1);
    rd_dv_i[idx] = 1'b1;
    rd_data_i[idx*16 +: 16] = d;
    tick();
    rd_dv_i = '0;
    check_eq({tag, "_rsp_vld"},  32'(rsp_valid_o), 32'd1);
    check_eq({tag, "_rsp_data"}, 32'(rsp_data_o), 32'(d));
    check_eq({tag, "_busy"},     32'(busy_o), 32'd1);
  endtask

  task automatic wait_rsp(input string tag, input logic [15:0] exp);
    int n = 0;
    while (!rsp_valid_o && n < 100) begin
      tick();
      n++;
    end
    check_eq({tag, "_vld"},  32'(rsp_valid_o), 32'd1);
    check_eq({tag, "_data"}, 32'(rsp_data_o), 32'(exp));
  endtask

  initial begin
    rst_n       = 1'b0;
    cmd_valid_i = 1'b0;
    cmd_data_i  = 16'h0000;
    rsp_busy_i  = 1'b0;
    rd_dv_i     = '0;
    rd_data_i   = '0;
    tick();
    tick();
    check_eq("rst_ready", 32'(cmd_ready_o), 32'd0);
    check_eq("rst_rsp_vld", 32'(rsp_valid_o), 32'd0);
    check_eq("rst_rsp_data", 32'(rsp_data_o), 32'd0);
    check_eq("rst_sel", 32'(select_module_o), 32'd0);
    check_eq("rst_rw_dv", {30'd0, r_w_o, dv_o}, 32'd0);
    check_eq("rst_data", 32'(data_o), 32'd0);
    check_eq("rst_busy_err", {30'd0, busy_o, err_o}, 32'd0);
    rst_n = 1'b1;
    tick();
    check_eq("rel_ready", 32'(cmd_ready_o), 32'd1);

    // WRITE to slave 2
    do_write("wr2", 8'd2, 8'h04, 16'h0010, 16'h0000);

    // READ from slave 2, with a stray pulse from slave 3 first
    send_word(16'h8002);
    check_eq("rd_sel", 32'(select_module_o), 32'h04);
    check_eq("rd_rw", 32'(r_w_o), 32'd0);
    rd_dv_i[3] = 1'b1;
    rd_data_i[3*16 +: 16] = 16'hBEEF;
    tick();
    rd_dv_i = '0;
    check_eq("rd_stray", 32'(rsp_valid_o), 32'd0);
    slave_word("rd_w0", 2, 16'h1234);
    tick();
    check_eq("rd_w0_retired", 32'(rsp_valid_o), 32'd0);
    slave_word("rd_w1", 2, 16'h0000);
    check_eq("rd_sel_drop", 32'(select_module_o), 32'd0);
    tick();
    check_eq("rd_done_ready", 32'(cmd_ready_o), 32'd1);
    check_eq("rd_done_vld", 32'(rsp_valid_o), 32'd0);

    // READ with host path stalled for 10 cycles
    rsp_busy_i = 1'b1;
    send_word(16'h8002);
    slave_word("bz_w0", 2, 16'hA5A5);
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("bz_hold_vld", 32'(rsp_valid_o), 32'd1);
      check_eq("bz_hold_data", 32'(rsp_data_o), 32'hA5A5);
      check_eq("bz_hold_busy", 32'(busy_o), 32'd1);
    end
    check_eq("bz_hold_sel", 32'(select_module_o), 32'h04);
    rsp_busy_i = 1'b0;
    tick();
    check_eq("bz_released", 32'(rsp_valid_o), 32'd0);
    slave_word("bz_w1", 2, 16'h5A5A);
    tick();
    check_eq("bz_err", 32'(err_o), 32'd0);

    // Out-of-range index, then a good WRITE
    send_word(16'h4008);
    check_eq("bad_idx_err", 32'(err_o), 32'd1);
    check_eq("bad_idx_sel", 32'(select_module_o), 32'd0);
    tick();
    check_eq("bad_idx_sel2", 32'(select_module_o), 32'd0);
    check_eq("bad_idx_ready", 32'(cmd_ready_o), 32'd1);
    do_write("wr0", 8'd0, 8'h01, 16'h1111, 16'h2222);

    // NOP then reserved opcode, then a good WRITE
    do_reset();
    send_word(16'h0003);
    check_eq("nop_sel", 32'(select_module_o), 32'd0);
    check_eq("nop_err", 32'(err_o), 32'd0);
    check_eq("nop_ready", 32'(cmd_ready_o), 32'd1);
    send_word(16'hC001);
    check_eq("rsvd_err", 32'(err_o), 32'd1);
    check_eq("rsvd_sel", 32'(select_module_o), 32'd0);
    do_write("wr7", 8'd7, 8'h80, 16'hCAFE, 16'hF00D);

    // READ to a silent slave: timeout after 255 counted cycles
    do_reset();
    send_word(16'h8005);
    repeat (255) tick();
    check_eq("to_err_early", 32'(err_o), 32'd0);
    check_eq("to_vld_early", 32'(rsp_valid_o), 32'd0);
    check_eq("to_sel", 32'(select_module_o), 32'h20);
    tick();
    check_eq("to_err", 32'(err_o), 32'd1);
    check_eq("to_w0_vld", 32'(rsp_valid_o), 32'd1);
    check_eq("to_w0_data", 32'(rsp_data_o), 32'hDEAD);
    tick();
    check_eq("to_w0_retired", 32'(rsp_valid_o), 32'd0);
    wait_rsp("to_w1", 16'hDEAD);
    tick();
    check_eq("to_idle_ready", 32'(cmd_ready_o), 32'd1);
    check_eq("to_idle_sel", 32'(select_module_o), 32'd0);

    // Reset while the write is between its two data beats
    do_reset();
    send_word(16'h4001);
    send_word(16'hAAAA);
    send_word(16'h5555);
    tick();
    check_eq("ab_lo_dv", 32'(dv_o), 32'd1);
    check_eq("ab_lo_data", 32'(data_o), 32'hAAAA);
    #2 rst_n = 1'b0;
    #1;
    check_eq("ab_sel", 32'(select_module_o), 32'd0);
    check_eq("ab_rw_dv", {30'd0, r_w_o, dv_o}, 32'd0);
    check_eq("ab_data", 32'(data_o), 32'd0);
    check_eq("ab_ready", 32'(cmd_ready_o), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("ab_rel_ready", 32'(cmd_ready_o), 32'd1);
    check_eq("ab_rel_sel", 32'(select_module_o), 32'd0);
    do_write("wr3", 8'd3, 8'h08, 16'h0F0F, 16'hF0F0);
    check_eq("ab_err", 32'(err_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/a_verif_cmd_master.md
# a_verif_cmd_master

Command initiator for the emulation control-verification bus. Accepts 16-bit instruction words from the host link, decodes them, and drives the per-module select/read-write/data-valid strobes that configuration slaves (cycle-count setters, verification launchers) consume. Collects the two-word readback those slaves return and forwards it to the host response path. Sits between the host link deserializer and the bank of control slaves, on the reference clock.

## Interface
- N_MOD, 8: number of addressable slave modules (≤ 256)
- TIMEOUT, 255: max clk_ref cycles to wait for each readback word
- clk_ref  in  1  reference clock, all logic rising edge
- rst_n  in  1  asynchronous, active-low reset
- cmd_valid_i  in  1  host command word valid
- cmd_data_i  in  16  host command word
- cmd_ready_o  out  1  master accepts cmd_data_i this cycle
- rsp_valid_o  out  1  response word valid
- rsp_data_o  out  16  response word
- rsp_busy_i  in  1  host response path full; hold rsp_valid_o/rsp_data_o
- select_module_o  out  N_MOD  one-hot slave select
- r_w_o  out  1  1 = write, 0 = read
- dv_o  out  1  write data valid strobe
- data_o  out  16  write data
- busy_o  out  1  to slaves' busy input; high while response register occupied
- rd_dv_i  in  N_MOD  per-slave readback valid pulse
- rd_data_i  in  16*N_MOD  per-slave readback data, slave k at [16k+15:16k]
- err_o  out  1  sticky error (bad index or timeout); cleared only by reset

## Operation
- Header word: [15:14] opcode (00 NOP, 01 WRITE, 10 READ, 11 reserved→error), [13:8] ignored, [7:0] slave index. Index ≥ N_MOD → err_o=1, command dropped, no select asserted, header consumed.
- WRITE: header + two payload words, low 16 bits first. Sequence on bus: ARM (select+r_w=1, dv=0, 1 cycle), WR_LO (select, r_w=1, dv=1, data_o=low), WR_HI (same, data_o=high). select held continuously ARM→WR_HI, deasserted the cycle after WR_HI.
- READ: select+r_w=0 held from RD_WAIT until second word captured. Slave word on rd_dv_i[idx] captured into response register as rsp word; first word = low, second = high. rd_dv_i of non-selected slaves ignored.
- NOP: consumed, no bus activity.
- States: IDLE → (WRITE) GET_LO → GET_HI → ARM → WR_LO → WR_HI → IDLE; (READ) RD_WAIT0 → RSP0 → RD_WAIT1 → RSP1 → IDLE. cmd_ready_o=1 only in IDLE, GET_LO, GET_HI.
- Timeout: counter (8+ bits, width ≥ clog2(TIMEOUT+1)) resets on entering each RD_WAIT; reaching TIMEOUT → err_o=1, response word 16'hDEAD emitted for each missing word, return IDLE.
- Response register 1-deep; busy_o = occupied. RSPx waits while register occupied; rd_dv during occupancy is not expected (slaves honour busy).

## Timing
- Reset: cmd_ready_o=0 (1 from first cycle after reset release), rsp_valid_o=0, rsp_data_o=0, select_module_o=0, r_w_o=0, dv_o=0, data_o=0, busy_o=0, err_o=0, state IDLE.
- All bus outputs registered. WRITE: select rises 1 cycle after high payload accepted; dv_o high exactly 2 consecutive cycles.
- READ: select rises 1 cycle after header accepted; rsp_valid_o rises 1 cycle after rd_dv_i capture.
- rsp_valid_o held with stable data while rsp_busy_i=1; word retired on cycle with rsp_valid_o=1 and rsp_busy_i=0.
- cmd_valid_i low in GET_LO/GET_HI: wait indefinitely, no timeout.
- Reset mid-command: all outputs to reset values immediately, partial write abandoned.

## Structure
- Package a_verif_cmd_pkg: opcode constants, state encoding, DEAD response constant, header field positions.
- Sub-module a_verif_rsp_reg: 1-deep response holding register (load, valid, busy, retire on !rsp_busy_i).

## Test plan
- WRITE idx 2, payload 16'h0010, 16'h0000 → select_module_o=8'h04, one ARM cycle, dv_o 2 cycles with data 0010 then 0000, no response.
- READ idx 2, slave pulses rd_dv_i[2] with 16'h1234 then 16'h0000 → rsp words 1234, 0000; select dropped after second.
- READ with rsp_busy_i=1 for 10 cycles → rsp_valid_o/data stable, busy_o=1, second word delivered after release.
- READ idx 5, slave silent → after 255 cycles err_o=1, two DEAD words, back to IDLE.
- Header idx 8 (N_MOD=8) or opcode 11 → err_o=1, no select, next valid WRITE still executes.
- rst_n low between WR_LO and WR_HI → all outputs 0 asynchronously; next command executes cleanly.
